// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit:
// state codes, opcodes, datapath select values and the opcode class bundle.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;
    localparam logic [1:0] SRC_A_ZERO  = 2'b11;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    localparam logic PC_SRC_ALU    = 1'b0;
    localparam logic PC_SRC_ALUOUT = 1'b1;

    typedef struct packed {
        logic r;
        logic i;
        logic lw;
        logic sw;
        logic br;
        logic jal;
        logic jalr;
        logic auipc;
        logic lui;
    } op_class_t;

endpackage

// File: rtl/multicycle_ctrl_opcode_class.sv
// Maps a 7-bit opcode onto a one-hot instruction class and a legal flag.
module opcode_class
    import multicycle_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_t  cls,
    output logic       legal
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_R:     cls.r     = 1'b1;
            OP_I:     cls.i     = 1'b1;
            OP_LW:    cls.lw    = 1'b1;
            OP_SW:    cls.sw    = 1'b1;
            OP_BR:    cls.br    = 1'b1;
            OP_JAL:   cls.jal   = 1'b1;
            OP_JALR:  cls.jalr  = 1'b1;
            OP_AUIPC: cls.auipc = 1'b1;
            OP_LUI:   cls.lui   = 1'b1;
            default:  cls = '0;
        endcase
    end

    assign legal = |cls;

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RISC-V control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// All outputs are decoded combinationally from state, opcode and handshakes.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_is_data,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] wb_sel,
    output logic       pc_src,
    output logic       instr_retired,
    output logic       illegal,
    output logic [2:0] state
);

    state_t    cur;
    state_t    nxt;
    op_class_t cls;
    logic      legal;

    opcode_class u_class (
        .opcode (opcode),
        .cls    (cls),
        .legal  (legal)
    );

    always_ff @(posedge clk) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt           = S_FETCH;
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_is_data   = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        alu_op        = ALU_ADD;
        wb_sel        = WB_ALUOUT;
        pc_src        = PC_SRC_ALU;
        instr_retired = 1'b0;
        illegal       = 1'b0;
        // Reset keeps every output at its idle default for the whole cycle.
        if (!reset) begin
            case (cur)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_a = SRC_A_PC;
                    alu_src_b = SRC_B_FOUR;
                    nxt       = S_FETCH;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        nxt      = S_DECODE;
                    end
                end
                S_DECODE: begin
                    alu_src_a = SRC_A_OLDPC;
                    alu_src_b = SRC_B_IMM;
                    nxt       = legal ? S_EXEC : S_TRAP;
                end
                S_EXEC: begin
                    nxt = S_WB;
                    unique case (1'b1)
                        cls.r: begin
                            alu_src_a = SRC_A_RS1;
                            alu_op    = ALU_FUNCT;
                        end
                        cls.i: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            alu_op    = ALU_FUNCT;
                        end
                        cls.lw, cls.sw: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                            nxt       = S_MEM;
                        end
                        cls.br: begin
                            alu_src_a     = SRC_A_RS1;
                            alu_op        = ALU_BRANCH;
                            pc_write      = branch_taken;
                            pc_src        = branch_taken;
                            instr_retired = 1'b1;
                            nxt           = S_FETCH;
                        end
                        cls.jal, cls.auipc: begin
                            alu_src_a = SRC_A_OLDPC;
                            alu_src_b = SRC_B_IMM;
                        end
                        cls.jalr: begin
                            alu_src_a = SRC_A_RS1;
                            alu_src_b = SRC_B_IMM;
                        end
                        cls.lui: begin
                            alu_src_a = SRC_A_ZERO;
                            alu_src_b = SRC_B_IMM;
                        end
                        default: nxt = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req     = 1'b1;
                    mem_is_data = 1'b1;
                    mem_we      = cls.sw;
                    nxt         = S_MEM;
                    if (mem_ready) begin
                        nxt           = cls.lw ? S_WB : S_FETCH;
                        instr_retired = !cls.lw;
                    end
                end
                S_WB: begin
                    reg_write     = 1'b1;
                    instr_retired = 1'b1;
                    if (cls.lw) begin
                        wb_sel = WB_MDR;
                    end else if (cls.jal || cls.jalr) begin
                        wb_sel   = WB_PC;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_ALUOUT;
                    end
                    nxt = S_FETCH;
                end
                S_TRAP: begin
                    illegal = 1'b1;
                    nxt     = S_TRAP;
                end
                default: nxt = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Trace-model bench: each instruction expands to its expected per-cycle rows.
// A negedge compare process checks every DUT output against the current row.
module tb_multicycle_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       req;
        logic       we;
        logic       isd;
        logic       irw;
        logic       pcw;
        logic       rw;
        logic [1:0] sa;
        logic [1:0] sb;
        logic [1:0] op;
        logic [1:0] wb;
        logic       ps;
        logic       ret;
        logic       ill;
    } out_t;

    typedef struct {
        logic       rst;
        logic       rdy;
        logic       tk;
        logic [6:0] opc;
        bit         chk;
        out_t       o;
    } row_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic       branch_taken = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, mem_is_data;
    logic       ir_write, pc_write, reg_write;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel;
    logic       pc_src, instr_retired, illegal;
    logic [2:0] state;

    multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .opcode        (opcode),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_is_data   (mem_is_data),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .wb_sel        (wb_sel),
        .pc_src        (pc_src),
        .instr_retired (instr_retired),
        .illegal       (illegal),
        .state         (state)
    );

    always #5 clk = ~clk;

    row_t q[$];
    out_t exp_o;
    bit   chk = 0;
    int   row_idx = 0;
    int   nchk = 0;
    int   nerr = 0;
    int   nret = 0;
    int   nrw = 0;

    function automatic row_t blank(input logic [2:0] st, input logic [6:0] opc);
        row_t r;
        r.rst  = 1'b0;
        r.rdy  = 1'b1;
        r.tk   = 1'b0;
        r.opc  = opc;
        r.chk  = 1'b1;
        r.o    = '0;
        r.o.st = st;
        return r;
    endfunction

    function automatic void push_reset(input logic [2:0] st, input logic [6:0] opc);
        row_t r;
        r     = blank(st, opc);
        r.rst = 1'b1;
        q.push_back(r);
    endfunction

    function automatic void push_wb(input logic [6:0] opc, input logic [1:0] wb, input logic jump);
        row_t r;
        r       = blank(3'd4, opc);
        r.o.rw  = 1'b1;
        r.o.ret = 1'b1;
        r.o.wb  = wb;
        r.o.pcw = jump;
        r.o.ps  = jump;
        q.push_back(r);
    endfunction

    // Expected trace of one instruction: FETCH waits, DECODE, then class path.
    function automatic void push_instr(input logic [6:0] opc, input int fw,
                                       input int mw, input logic tk,
                                       input int trap_n, input bit cut_mem);
        row_t r;
        for (int i = 0; i <= fw; i++) begin
            r       = blank(3'd0, opc);
            r.rdy   = (i == fw);
            r.o.req = 1'b1;
            r.o.sb  = 2'b10;
            r.o.irw = (i == fw);
            r.o.pcw = (i == fw);
            q.push_back(r);
        end
        r      = blank(3'd1, opc);
        r.o.sa = 2'b01;
        r.o.sb = 2'b01;
        q.push_back(r);
        r = blank(3'd2, opc);
        case (opc)
            7'b0110011: begin
                r.o.sa = 2'b10; r.o.op = 2'b10; q.push_back(r);
                push_wb(opc, 2'b00, 1'b0);
            end
            7'b0010011: begin
                r.o.sa = 2'b10; r.o.sb = 2'b01; r.o.op = 2'b10; q.push_back(r);
                push_wb(opc, 2'b00, 1'b0);
            end
            7'b0000011, 7'b0100011: begin
                r.o.sa = 2'b10; r.o.sb = 2'b01; q.push_back(r);
                if (cut_mem) begin
                    push_reset(3'd3, opc);
                end else begin
                    for (int i = 0; i <= mw; i++) begin
                        r       = blank(3'd3, opc);
                        r.rdy   = (i == mw);
                        r.o.req = 1'b1;
                        r.o.isd = 1'b1;
                        r.o.we  = (opc == 7'b0100011);
                        r.o.ret = (i == mw) && (opc == 7'b0100011);
                        q.push_back(r);
                    end
                    if (opc == 7'b0000011) push_wb(opc, 2'b01, 1'b0);
                end
            end
            7'b1100011: begin
                r.tk = tk; r.o.sa = 2'b10; r.o.op = 2'b01;
                r.o.pcw = tk; r.o.ps = tk; r.o.ret = 1'b1;
                q.push_back(r);
            end
            7'b1101111: begin
                r.o.sa = 2'b01; r.o.sb = 2'b01; q.push_back(r);
                push_wb(opc, 2'b10, 1'b1);
            end
            7'b1100111: begin
                r.o.sa = 2'b10; r.o.sb = 2'b01; q.push_back(r);
                push_wb(opc, 2'b10, 1'b1);
            end
            7'b0010111: begin
                r.o.sa = 2'b01; r.o.sb = 2'b01; q.push_back(r);
                push_wb(opc, 2'b00, 1'b0);
            end
            7'b0110111: begin
                r.o.sa = 2'b11; r.o.sb = 2'b01; q.push_back(r);
                push_wb(opc, 2'b00, 1'b0);
            end
            default: begin
                for (int i = 0; i < trap_n; i++) begin
                    r       = blank(3'd5, opc);
                    r.o.ill = 1'b1;
                    q.push_back(r);
                end
            end
        endcase
    endfunction

    task automatic check_int(input string name, input int act, input int req);
        nchk++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        out_t act;
        if (chk) begin
            act.st  = state;
            act.req = mem_req;
            act.we  = mem_we;
            act.isd = mem_is_data;
            act.irw = ir_write;
            act.pcw = pc_write;
            act.rw  = reg_write;
            act.sa  = alu_src_a;
            act.sb  = alu_src_b;
            act.op  = alu_op;
            act.wb  = wb_sel;
            act.ps  = pc_src;
            act.ret = instr_retired;
            act.ill = illegal;
            nchk++;
            if (act !== exp_o) begin
                nerr++;
                $display("FAIL row %0d outputs: got %h, required %h", row_idx, act, exp_o);
            end
            if (instr_retired === 1'b1) nret++;
            if (reg_write === 1'b1) nrw++;
        end
    end

    initial begin
        int n0;
        row_t r;
        r     = blank(3'd0, 7'd0);
        r.rst = 1'b1;
        r.chk = 1'b0;
        q.push_back(r);
        push_reset(3'd0, 7'd0);

        n0 = q.size(); push_instr(7'b0110011, 0, 0, 0, 0, 0);
        check_int("add_cycles", q.size() - n0, 4);
        n0 = q.size(); push_instr(7'b0000011, 2, 3, 0, 0, 0);
        check_int("lw_wait_cycles", q.size() - n0, 10);
        n0 = q.size(); push_instr(7'b1100011, 0, 0, 1, 0, 0);
        check_int("br_taken_cycles", q.size() - n0, 3);
        n0 = q.size(); push_instr(7'b1100011, 0, 0, 0, 0, 0);
        check_int("br_not_cycles", q.size() - n0, 3);
        push_instr(7'b1100111, 0, 0, 0, 0, 0);
        push_instr(7'b1101111, 0, 0, 0, 0, 0);
        push_instr(7'b0010111, 0, 0, 0, 0, 0);
        push_instr(7'b0110111, 0, 0, 0, 0, 0);
        push_instr(7'b0010011, 1, 0, 0, 0, 0);
        push_instr(7'b0100011, 1, 1, 0, 0, 0);
        n0 = q.size(); push_instr(7'b0000011, 0, 0, 0, 0, 0);
        check_int("lw_zero_wait_cycles", q.size() - n0, 5);
        push_instr(7'b0100011, 0, 0, 0, 0, 1);
        push_instr(7'b1111111, 0, 0, 0, 20, 0);
        push_reset(3'd5, 7'b1111111);
        push_instr(7'b0110011, 0, 0, 0, 0, 0);

        @(posedge clk);
        #1;
        foreach (q[i]) begin
            row_idx      = i;
            reset        = q[i].rst;
            mem_ready    = q[i].rdy;
            branch_taken = q[i].tk;
            opcode       = q[i].opc;
            exp_o        = q[i].o;
            chk          = q[i].chk;
            @(posedge clk);
            #1;
        end
        chk = 0;

        check_int("retired_total", nret, 12);
        check_int("reg_write_total", nrw, 9);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
